// File: rtl/gf_pkg.sv
// Shared types and constants for the GF(2^M) pipelined ALU.
package gf_pkg;

    // Operation codes as seen on the op port
    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_MUL = 2'b01,
        OP_DIV = 2'b10,
        OP_INV = 2'b11
    } gf_op_e;

    // Controller states: table build, then normal operation
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } gf_state_e;

    // Default field: GF(8) generated by x^3 + x + 1
    localparam int         GF_M_DEF         = 3;
    localparam logic [3:0] GF_PRIM_POLY_DEF = 4'b1011;

endpackage

// File: rtl/gf_log_tables.sv
// Exponent/logarithm tables for GF(2^M), built at start-up by walking an
// LFSR under the primitive polynomial. One entry of each table is written
// per cycle while init_en is high; 'last' flags the final write.
module gf_log_tables
    import gf_pkg::*;
#(
    parameter int         M         = GF_M_DEF,
    parameter logic [M:0] PRIM_POLY = (M+1)'(GF_PRIM_POLY_DEF)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         init_en,
    output logic         last,
    input  logic [M-1:0] exp_addr0,
    input  logic [M-1:0] exp_addr1,
    output logic [M-1:0] exp_data0,
    output logic [M-1:0] exp_data1,
    input  logic [M-1:0] log_addr,
    output logic [M-1:0] log_data
);

    localparam int N = (1 << M) - 1;

    // exp_tbl[k] = alpha^k (polynomial form); log_tbl[alpha^k] = k.
    // Both are sized 2^M: exp_tbl[N] and log_tbl[0] are never written and
    // never selected by the datapath.
    logic [M-1:0] exp_tbl [0:(1<<M)-1];
    logic [M-1:0] log_tbl [0:(1<<M)-1];

    logic [M-1:0] lfsr;
    logic [M-1:0] cnt;
    logic         done;
    logic         wr_en;

    // Multiply the current power of alpha by alpha, reducing by PRIM_POLY
    function automatic logic [M-1:0] lfsr_next(input logic [M-1:0] l);
        logic [M-1:0] shifted;
        shifted = {l[M-2:0], 1'b0};
        if (l[M-1]) begin
            shifted = shifted ^ PRIM_POLY[M-1:0];
        end
        return shifted;
    endfunction

    assign wr_en = init_en && !done;
    assign last  = wr_en && (cnt == M'(N-1));

    // Walk alpha^0 .. alpha^(N-1); reset re-seeds the walk at alpha^0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr <= M'(1);
            cnt  <= '0;
            done <= 1'b0;
        end else if (wr_en) begin
            lfsr <= lfsr_next(lfsr);
            cnt  <= cnt + M'(1);
            done <= last;
        end
    end

    // Table storage is pure data and is simply rewritten after each reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            exp_tbl[cnt]  <= lfsr;
            log_tbl[lfsr] <= cnt;
        end
    end

    assign exp_data0 = exp_tbl[exp_addr0];
    assign exp_data1 = exp_tbl[exp_addr1];
    assign log_data  = log_tbl[log_addr];

endmodule

// File: rtl/gf_alu_pipe.sv
// Two-stage pipelined GF(2^M) ALU working on index-form symbols
// (0 = zero, k = alpha^(k-1)). Supports ADD/MUL always; DIV/INV only when
// the macro GF_ALU_DIV_EN is defined, otherwise ops 10/11 return out=0,
// err=1 with normal latency. Tables are rebuilt after every reset, during
// which in_ready is held low.
module gf_alu_pipe
    import gf_pkg::*;
#(
    parameter int         M         = GF_M_DEF,
    parameter logic [M:0] PRIM_POLY = (M+1)'(GF_PRIM_POLY_DEF)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   op,
    input  logic [M-1:0] in0,
    input  logic [M-1:0] in1,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [M-1:0] out,
    output logic         err,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int N = (1 << M) - 1;

    gf_state_e state_q;
    gf_state_e state_d;

    logic tbl_last;
    logic advance;
    logic accept;

    // Stage p0: registered request
    logic         vld_p0;
    gf_op_e       op_p0;
    logic [M-1:0] a_p0;
    logic [M-1:0] b_p0;

    // Combinational result computed from stage p0
    logic [M-1:0] res_p0;
    logic         res_err_p0;
    logic [M-1:0] exp_a_p0;
    logic [M-1:0] exp_b_p0;
    logic [M-1:0] sum_poly_p0;
    logic [M-1:0] log_sum_p0;

    // Stage p1: registered response
    logic         vld_p1;
    logic [M-1:0] out_p1;
    logic         err_p1;

    // ((a-1) + (b-1)) mod N + 1 for nonzero a, b
    function automatic logic [M-1:0] idx_mul(input logic [M-1:0] a,
                                             input logic [M-1:0] b);
        logic [M:0] s;
        s = {1'b0, a} + {1'b0, b} - (M+1)'(2);
        if (s >= (M+1)'(N)) begin
            s = s - (M+1)'(N);
        end
        return s[M-1:0] + M'(1);
    endfunction

`ifdef GF_ALU_DIV_EN
    // ((a-1) - (b-1)) mod N + 1 for nonzero a, b, wrapped non-negative
    function automatic logic [M-1:0] idx_div(input logic [M-1:0] a,
                                             input logic [M-1:0] b);
        logic signed [M+1:0] d;
        d = $signed({2'b00, a}) - $signed({2'b00, b});
        if (d < 0) begin
            d = d + $signed((M+2)'(N));
        end
        return d[M-1:0] + M'(1);
    endfunction

    // Index of the inverse of nonzero a; alpha^0 is its own inverse
    function automatic logic [M-1:0] idx_inv(input logic [M-1:0] a);
        logic [M:0] s;
        if (a == M'(1)) begin
            return M'(1);
        end
        s = (M+1)'(N) - {1'b0, a} + (M+1)'(2);
        return s[M-1:0];
    endfunction
`endif

    gf_log_tables #(
        .M         (M),
        .PRIM_POLY (PRIM_POLY)
    ) u_tables (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_en   (state_q == ST_INIT),
        .last      (tbl_last),
        .exp_addr0 (a_p0 - M'(1)),
        .exp_addr1 (b_p0 - M'(1)),
        .exp_data0 (exp_a_p0),
        .exp_data1 (exp_b_p0),
        .log_addr  (sum_poly_p0),
        .log_data  (log_sum_p0)
    );

    assign advance     = !vld_p1 || out_ready;
    assign accept      = in_valid && in_ready;
    assign sum_poly_p0 = exp_a_p0 ^ exp_b_p0;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: leave INIT once the last table entry is written
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (tbl_last) state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    // FSM outputs: accept only in RUN and only when the pipe can move
    always_comb begin
        in_ready = 1'b0;
        if (state_q == ST_RUN) begin
            in_ready = advance;
        end
    end

    // ---- stage p0: capture request ----
    // Stage p0 valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
        end else if (advance) begin
            vld_p0 <= accept;
        end
    end

    // Stage p0 operands, latched only on an accepted request
    always_ff @(posedge clk) begin
        if (advance && accept) begin
            op_p0 <= gf_op_e'(op);
            a_p0  <= in0;
            b_p0  <= in1;
        end
    end

    // ---- stage p0 -> p1: field arithmetic ----
    // Evaluate the registered request
    always_comb begin
        res_p0     = '0;
        res_err_p0 = 1'b0;
        case (op_p0)
            OP_ADD: begin
                if (a_p0 == '0) begin
                    res_p0 = b_p0;
                end else if (b_p0 == '0) begin
                    res_p0 = a_p0;
                end else if (sum_poly_p0 != '0) begin
                    res_p0 = log_sum_p0 + M'(1);
                end
            end
            OP_MUL: begin
                if ((a_p0 != '0) && (b_p0 != '0)) begin
                    res_p0 = idx_mul(a_p0, b_p0);
                end
            end
`ifdef GF_ALU_DIV_EN
            OP_DIV: begin
                if (b_p0 == '0) begin
                    res_err_p0 = 1'b1;
                end else if (a_p0 != '0) begin
                    res_p0 = idx_div(a_p0, b_p0);
                end
            end
            OP_INV: begin
                if (a_p0 == '0) begin
                    res_err_p0 = 1'b1;
                end else begin
                    res_p0 = idx_inv(a_p0);
                end
            end
`else
            OP_DIV, OP_INV: begin
                res_err_p0 = 1'b1;
            end
`endif
            default: begin
                res_p0     = '0;
                res_err_p0 = 1'b0;
            end
        endcase
    end

    // ---- stage p1: registered response ----
    // Output register; holds while the consumer stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            out_p1 <= '0;
            err_p1 <= 1'b0;
        end else if (advance) begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                out_p1 <= res_p0;
                err_p1 <= res_err_p0;
            end
        end
    end

    assign out_valid = vld_p1;
    assign out       = out_p1;
    assign err       = err_p1;

endmodule

// File: tb/tb_gf_alu_pipe.sv
// Scoreboard bench for gf_alu_pipe (M=3, x^3+x+1). Directed vectors carry
// hand-computed index-form results; DIV/INV expectations follow whether
// GF_ALU_DIV_EN is defined for the build.
module tb_gf_alu_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] op;
    logic [2:0] in0;
    logic [2:0] in1;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] out;
    logic       err;
    logic       out_valid;
    logic       out_ready;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_cnt = 0;
    bit flushing = 1'b1;

    typedef struct {
        logic [2:0] o;
        logic       e;
        int         acc;
        bit         lat;
        int         idx;
    } exp_t;

    exp_t sb[$];

    // Directed vectors: op, in0, in1, expected out, expected err (divide enabled)
    int v_op[20] = '{0, 0, 0, 0, 1, 1, 1, 2, 3, 2, 3, 2, 3, 0, 1, 2, 0, 1, 3, 2};
    int v_a [20] = '{2, 5, 0, 4, 6, 0, 7, 2, 3, 4, 1, 0, 0, 1, 1, 5, 7, 3, 7, 3};
    int v_b [20] = '{3, 5, 6, 0, 5, 4, 7, 4, 5, 0, 2, 3, 7, 4, 5, 5, 6, 7, 0, 6};
    int v_r [20] = '{5, 0, 6, 4, 3, 0, 6, 6, 6, 0, 1, 0, 0, 2, 5, 1, 2, 2, 2, 5};
    int v_e [20] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};

    gf_alu_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op        (op),
        .in0       (in0),
        .in1       (in1),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .err       (err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic exp_t expect_of(input int i);
        exp_t x;
        x.o   = 3'(v_r[i]);
        x.e   = v_e[i][0];
`ifndef GF_ALU_DIV_EN
        if (v_op[i] >= 2) begin
            x.o = 3'd0;
            x.e = 1'b1;
        end
`endif
        x.acc = 0;
        x.lat = 1'b0;
        x.idx = i;
        return x;
    endfunction

    // Monitor: pops the scoreboard on every output transfer
    initial begin : monitor
        bit         prev_stall = 1'b0;
        logic [2:0] h_out;
        logic       h_err;
        exp_t       x;
        forever begin
            @(negedge clk);
            #1;
            if (flushing || !rst_n) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall) begin
                n_tests++;
                if (!out_valid || out !== h_out || err !== h_err) begin
                    n_fail++;
                    $display("FAIL hold: got valid=%0b out=%0d err=%0b, required valid=1 out=%0d err=%0b",
                             out_valid, out, err, h_out, h_err);
                end
            end
            if (out_valid && out_ready) begin
                prev_stall = 1'b0;
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: got out=%0d err=%0b, required no output", out, err);
                end else begin
                    x = sb.pop_front();
                    if (out !== x.o || err !== x.e) begin
                        n_fail++;
                        $display("FAIL vec%0d: got out=%0d err=%0b, required out=%0d err=%0b",
                                 x.idx, out, err, x.o, x.e);
                    end
                    if (x.lat) begin
                        n_tests++;
                        if (cyc_cnt - x.acc != 2) begin
                            n_fail++;
                            $display("FAIL latency vec%0d: got %0d cycles, required 2",
                                     x.idx, cyc_cnt - x.acc);
                        end
                    end
                end
            end else if (out_valid) begin
                prev_stall = 1'b1;
                h_out      = out;
                h_err      = err;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    // Count INIT cycles with in_ready low; called at the release negedge
    task automatic init_check();
        int lowc = 0;
        bit bad  = 1'b0;
        while (!in_ready && lowc < 50) begin
            if (out_valid) bad = 1'b1;
            lowc++;
            @(negedge clk);
        end
        n_tests++;
        if (lowc != 7) begin
            n_fail++;
            $display("FAIL init_len: got %0d cycles with in_ready=0, required 7", lowc);
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL init_valid: got out_valid=1 during INIT, required 0");
        end
    endtask

    // Stream cnt vectors from 'first'; out_ready low for stall_len cycles at stall_at
    task automatic stream(input int first, input int cnt, input int stall_at,
                          input int stall_len, input bit lat);
        int   sent = 0;
        int   cyc  = 0;
        exp_t x;
        while (sent < cnt && cyc < 200) begin
            out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            in_valid  = 1'b1;
            op        = 2'(v_op[first + sent]);
            in0       = 3'(v_a[first + sent]);
            in1       = 3'(v_b[first + sent]);
            #1;
            if (in_ready) begin
                x     = expect_of(first + sent);
                x.acc = cyc_cnt;
                x.lat = lat;
                sb.push_back(x);
                sent++;
            end else if (!out_ready && out_valid) begin
                n_tests++;
            end
            if (!out_ready && out_valid && in_ready) begin
                n_tests++;
                n_fail++;
                $display("FAIL stall_ready: got in_ready=1, required 0");
            end
            cyc++;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (sent < cnt) begin
            n_tests++;
            n_fail++;
            $display("FAIL stream_timeout: got %0d accepted, required %0d", sent, cnt);
        end
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        repeat (4) @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d results missing, required 0", sb.size());
        end
    endtask

    task automatic check_idle(input string name);
        n_tests++;
        if (out_valid !== 1'b0 || out !== 3'd0 || err !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got valid=%0b out=%0d err=%0b in_ready=%0b, required all 0",
                     name, out_valid, out, err, in_ready);
        end
    endtask

    initial begin : timeout
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 2'd0;
        in0       = 3'd0;
        in1       = 3'd0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("reset_state");

        rst_n    = 1'b1;
        flushing = 1'b0;
        init_check();

        // Back-to-back, no stall: every result exactly 2 cycles after acceptance
        stream(0, 20, 1000, 0, 1'b1);
        drain();

        // Consumer stall for 3 cycles mid-stream
        stream(0, 12, 4, 3, 1'b0);
        drain();

        // Reset while requests are in flight
        stream(0, 5, 1000, 0, 1'b0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        flushing = 1'b1;
        sb.delete();
        @(negedge clk);
        check_idle("mid_reset");
        @(negedge clk);
        rst_n    = 1'b1;
        flushing = 1'b0;
        init_check();

        // Operation resumes with freshly built tables
        stream(13, 7, 1000, 0, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
